// File: rtl/i2c_slave_engine.sv
// Bit-level I2C slave front end: pin conditioning, START/STOP detection, address match,
// byte deserialise/serialise and ACK handling for the downstream register driver.
module i2c_slave_engine #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [6:0] address,
  input  logic [7:0] datasend,
  output logic       sended,
  output logic [7:0] datareceive,
  output logic       received,
  output logic       busy
);

  localparam int unsigned CntW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StWaitStop
  } state_e;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]           sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntW'(FILTER_LEN - 1)) filt_d[i] = sync2_q[i];
        else                                   cnt_d[i]  = cnt_q[i] + CntW'(1);
      end
    end
  end

  logic scl_r, scl_f, scl_hi, sda_r, sda_f, sda_bit, start_det, stop_det;

  assign scl_r   = filt_q[0] & ~filt_prev_q[0];
  assign scl_f   = ~filt_q[0] & filt_prev_q[0];
  assign scl_hi  = filt_q[0] & filt_prev_q[0];
  assign sda_r   = filt_q[1] & ~filt_prev_q[1];
  assign sda_f   = ~filt_q[1] & filt_prev_q[1];
  assign sda_bit = filt_q[1];
  // SCL must be steadily high so a coincident SCL edge is treated as a data bit.
  assign start_det = sda_f & scl_hi;
  assign stop_det  = sda_r & scl_hi;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] datareceive_q, datareceive_d;
  logic       rw_q, rw_d;
  logic       pend_q, pend_d;
  logic       sda_oe_q, sda_oe_d;
  logic       sended_q, sended_d;
  logic       received_q, received_d;
  logic       busy_q, busy_d;
  logic [7:0] byte_full;

  assign byte_full = {shift_q[6:0], sda_bit};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    datareceive_d = datareceive_q;
    rw_d          = rw_q;
    pend_d        = pend_q;
    sda_oe_d      = sda_oe_q;
    sended_d      = 1'b0;
    received_d    = 1'b0;
    busy_d        = busy_q;

    case (state_q)
      StAddr: begin
        if (scl_r) begin
          shift_d   = byte_full;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_full[7:1] == address) begin
              rw_d   = byte_full[0];
              pend_d = 1'b1;
            end else begin
              state_d = StWaitStop;
            end
          end
        end else if (scl_f && pend_q) begin
          pend_d    = 1'b0;
          sda_oe_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = StAddrAck;
        end
      end
      StAddrAck: begin
        if (scl_f) begin
          bit_cnt_d = '0;
          if (rw_q) begin
            shift_d  = datasend;
            sda_oe_d = ~datasend[7];
            state_d  = StRead;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = StWrite;
          end
        end
      end
      StWrite: begin
        if (scl_r) begin
          shift_d   = byte_full;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            datareceive_d = byte_full;
            received_d    = 1'b1;
            pend_d        = 1'b1;
          end
        end else if (scl_f && pend_q) begin
          pend_d    = 1'b0;
          sda_oe_d  = 1'b1;
          bit_cnt_d = '0;
          state_d   = StWriteAck;
        end
      end
      StWriteAck: begin
        if (scl_f) begin
          sda_oe_d = 1'b0;
          state_d  = StWrite;
        end
      end
      StRead: begin
        if (scl_f) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StReadAck;
          end else begin
            shift_d   = {shift_q[6:0], 1'b0};
            sda_oe_d  = ~shift_q[6];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StReadAck: begin
        if (scl_r) begin
          if (!sda_bit) begin
            sended_d = 1'b1;
            pend_d   = 1'b1;
          end else begin
            state_d = StWaitStop;
          end
        end else if (scl_f && pend_q) begin
          pend_d   = 1'b0;
          shift_d  = datasend;
          sda_oe_d = ~datasend[7];
          state_d  = StRead;
        end
      end
      StIdle, StWaitStop: ;
      default: state_d = StIdle;
    endcase

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d  = StIdle;
      pend_d   = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      filt_q        <= 2'b11;
      filt_prev_q   <= 2'b11;
      cnt_q         <= '0;
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      datareceive_q <= '0;
      rw_q          <= 1'b0;
      pend_q        <= 1'b0;
      sda_oe_q      <= 1'b0;
      sended_q      <= 1'b0;
      received_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync1_q       <= {sda_in, scl_in};
      sync2_q       <= sync1_q;
      filt_q        <= filt_d;
      filt_prev_q   <= filt_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      datareceive_q <= datareceive_d;
      rw_q          <= rw_d;
      pend_q        <= pend_d;
      sda_oe_q      <= sda_oe_d;
      sended_q      <= sended_d;
      received_q    <= received_d;
      busy_q        <= busy_d;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign sended      = sended_q;
  assign received    = received_q;
  assign datareceive = datareceive_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_slave_engine.sv
// Bench for i2c_slave_engine: a bit-banged I2C master drives the pins and results are
// compared against transaction-level expectations (ack, bytes, pulse counts).
module tb_i2c_slave_engine;

  localparam int unsigned FilterLen = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [6:0] address;
  logic [7:0] datasend;
  logic       sended;
  logic [7:0] datareceive;
  logic       received;
  logic       busy;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_engine #(.FILTER_LEN(FilterLen)) u_dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .address(address), .datasend(datasend), .sended(sended), .datareceive(datareceive),
    .received(received), .busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int         tx_cnt = 0;
  int         oe_cnt = 0;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (received) rx_log.push_back(datareceive);
    if (sended) tx_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period: 20 clk low (data set halfway), 20 clk high (sampled halfway).
  task automatic clk_bit(input logic b, input logic glitch, output logic s, output logic oe);
    sda_m = b;
    wait_clks(10);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clks(4);
      scl_m = 1'b0;
      wait_clks(1);
      scl_m = 1'b1;
      wait_clks(5);
    end else begin
      wait_clks(10);
    end
    s  = sda_line;
    oe = sda_oe;
    wait_clks(10);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(20);
    sda_m = 1'b0;
    wait_clks(20);
    scl_m = 1'b0;
    wait_clks(10);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_clks(10);
    scl_m = 1'b1;
    wait_clks(20);
    sda_m = 1'b1;
    wait_clks(20);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [8:0] glitch, output logic acked,
                           output logic oe9);
    logic s, oe;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], glitch[i], s, oe);
    clk_bit(1'b1, glitch[8], s, oe9);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic mack, input logic [7:0] next_ds, output logic [7:0] d);
    logic s, oe;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, 1'b0, s, oe);
      d = {d[6:0], s};
    end
    datasend = next_ds;
    clk_bit(~mack, 1'b0, s, oe);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; address = 7'h3C; datasend = 8'h00;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
    tests_run++;
    if (sda_oe !== 1'b0) begin
      tests_failed++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe);
    end
    tests_run++;
    if (sended !== 1'b0) begin
      tests_failed++; $display("FAIL reset_sended: got %b expected 0", sended);
    end
    tests_run++;
    if (received !== 1'b0) begin
      tests_failed++; $display("FAIL reset_received: got %b expected 0", received);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (datareceive !== 8'h00) begin
      tests_failed++; $display("FAIL reset_datareceive: got %h expected 00", datareceive);
    end
    reset = 1'b1;
    wait_clks(20);
  endtask

  task automatic test_write();
    logic ack, oe9;
    int   rx0;
    address = 7'h3C;
    rx0 = rx_log.size();
    bus_start();
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL write_busy_start: got %b expected 1", busy);
    end
    send_byte(8'h78, 9'h0, ack, oe9);
    tests_run++;
    if (oe9 !== 1'b1) begin
      tests_failed++; $display("FAIL write_addr_ack_oe: got %b expected 1", oe9);
    end
    send_byte(8'h01, 9'h0, ack, oe9);
    tests_run++;
    if (oe9 !== 1'b1) begin
      tests_failed++; $display("FAIL write_data_ack_oe: got %b expected 1", oe9);
    end
    bus_stop();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL write_busy_stop: got %b expected 0", busy);
    end
    tests_run++;
    if (rx_log.size() - rx0 != 1) begin
      tests_failed++;
      $display("FAIL write_rx_count: got %0d expected 1", rx_log.size() - rx0);
    end else begin
      tests_run++;
      if (rx_log[rx0] !== 8'h01) begin
        tests_failed++; $display("FAIL write_rx_data: got %h expected 01", rx_log[rx0]);
      end
    end
  endtask

  task automatic test_mismatch();
    logic ack, oe9;
    int   rx0, oe0;
    address = 7'h3C;
    rx0 = rx_log.size();
    oe0 = oe_cnt;
    bus_start();
    send_byte(8'h7A, 9'h0, ack, oe9);
    tests_run++;
    if (ack !== 1'b0) begin
      tests_failed++; $display("FAIL mismatch_addr_ack: got %b expected 0", ack);
    end
    send_byte(8'h55, 9'h0, ack, oe9);
    send_byte(8'hAA, 9'h0, ack, oe9);
    bus_stop();
    tests_run++;
    if (oe_cnt != oe0) begin
      tests_failed++; $display("FAIL mismatch_oe_cycles: got %0d expected 0", oe_cnt - oe0);
    end
    tests_run++;
    if (rx_log.size() != rx0) begin
      tests_failed++;
      $display("FAIL mismatch_rx_count: got %0d expected 0", rx_log.size() - rx0);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL mismatch_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_read_rs();
    logic       ack, oe9;
    logic [7:0] d;
    int         rx0, tx0;
    address = 7'h3C;
    rx0 = rx_log.size();
    bus_start();
    send_byte(8'h78, 9'h0, ack, oe9);
    send_byte(8'h02, 9'h0, ack, oe9);
    datasend = 8'hAB;
    bus_start();
    send_byte(8'h79, 9'h0, ack, oe9);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++; $display("FAIL rs_read_addr_ack: got %b expected 1", ack);
    end
    tx0 = tx_cnt;
    recv_byte(1'b1, 8'hCD, d);
    tests_run++;
    if (d !== 8'hAB) begin
      tests_failed++; $display("FAIL rs_read_byte1: got %h expected ab", d);
    end
    recv_byte(1'b0, 8'h00, d);
    tests_run++;
    if (d !== 8'hCD) begin
      tests_failed++; $display("FAIL rs_read_byte2: got %h expected cd", d);
    end
    bus_stop();
    tests_run++;
    if (tx_cnt - tx0 != 1) begin
      tests_failed++; $display("FAIL rs_sended_count: got %0d expected 1", tx_cnt - tx0);
    end
    tests_run++;
    if (rx_log.size() - rx0 != 1 || rx_log[rx_log.size() - 1] !== 8'h02) begin
      tests_failed++;
      $display("FAIL rs_reg_write: got %0d bytes, last %h; expected 1 byte 02",
               rx_log.size() - rx0, rx_log[rx_log.size() - 1]);
    end
  endtask

  task automatic test_glitch();
    logic       ack, oe9;
    logic [7:0] d0, d1;
    int         rx0;
    address = 7'h3C;
    d0 = 8'($urandom_range(0, 255));
    d1 = 8'($urandom_range(0, 255));
    rx0 = rx_log.size();
    bus_start();
    send_byte(8'h78, 9'h010, ack, oe9);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++; $display("FAIL glitch_addr_ack: got %b expected 1", ack);
    end
    send_byte(d0, 9'h124, ack, oe9);
    send_byte(d1, 9'h0, ack, oe9);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++; $display("FAIL glitch_data_ack: got %b expected 1", ack);
    end
    bus_stop();
    tests_run++;
    if (rx_log.size() - rx0 != 2) begin
      tests_failed++;
      $display("FAIL glitch_rx_count: got %0d expected 2", rx_log.size() - rx0);
    end else begin
      tests_run++;
      if (rx_log[rx0] !== d0 || rx_log[rx0 + 1] !== d1) begin
        tests_failed++;
        $display("FAIL glitch_rx_data: got %h %h expected %h %h",
                 rx_log[rx0], rx_log[rx0 + 1], d0, d1);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic       ack, oe9, s, oe;
    logic [7:0] d0;
    int         rx0;
    address  = 7'h3C;
    datasend = 8'h00;
    bus_start();
    send_byte(8'h79, 9'h0, ack, oe9);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, 1'b0, s, oe);
    tests_run++;
    if (sda_oe !== 1'b1) begin
      tests_failed++; $display("FAIL midread_oe_before_reset: got %b expected 1", sda_oe);
    end
    rx0 = rx_log.size();
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (sda_oe !== 1'b0) begin
      tests_failed++; $display("FAIL midread_oe_on_reset: got %b expected 0", sda_oe);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL midread_busy_on_reset: got %b expected 0", busy);
    end
    wait_clks(3);
    reset = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clks(40);
    d0 = 8'($urandom_range(0, 255));
    bus_start();
    send_byte(8'h78, 9'h0, ack, oe9);
    tests_run++;
    if (ack !== 1'b1) begin
      tests_failed++; $display("FAIL after_reset_addr_ack: got %b expected 1", ack);
    end
    send_byte(d0, 9'h0, ack, oe9);
    bus_stop();
    tests_run++;
    if (rx_log.size() - rx0 != 1 || rx_log[rx_log.size() - 1] !== d0) begin
      tests_failed++;
      $display("FAIL after_reset_rx: got %0d bytes, last %h; expected 1 byte %h",
               rx_log.size() - rx0, rx_log[rx_log.size() - 1], d0);
    end
  endtask

  // Random transactions checked against transaction-level rules.
  task automatic test_random();
    logic [6:0] own, tgt;
    logic       rw, exp_ack, ack, oe9;
    logic [7:0] bytes[4];
    logic [7:0] d, exp_d;
    int         n, rx0, tx0, exp_rx;
    for (int t = 0; t < 12; t++) begin
      own = 7'($urandom_range(0, 127));
      tgt = ($urandom_range(0, 1) == 1) ? own : own ^ 7'($urandom_range(1, 127));
      rw  = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom_range(0, 255));
      exp_ack  = (tgt == own);
      address  = own;
      datasend = bytes[0];
      rx0 = rx_log.size();
      tx0 = tx_cnt;
      bus_start();
      send_byte({tgt, rw}, 9'h0, ack, oe9);
      tests_run++;
      if (ack !== exp_ack) begin
        tests_failed++;
        $display("FAIL rand%0d_addr_ack: got %b expected %b (addr %h own %h)",
                 t, ack, exp_ack, tgt, own);
      end
      for (int k = 0; k < n; k++) begin
        if (rw) begin
          recv_byte(k != n - 1, bytes[k + 1], d);
          exp_d = exp_ack ? bytes[k] : 8'hFF;
          tests_run++;
          if (d !== exp_d) begin
            tests_failed++;
            $display("FAIL rand%0d_read_byte%0d: got %h expected %h", t, k, d, exp_d);
          end
        end else begin
          send_byte(bytes[k], 9'h0, ack, oe9);
        end
      end
      bus_stop();
      exp_rx = (exp_ack && !rw) ? n : 0;
      tests_run++;
      if (rx_log.size() - rx0 != exp_rx) begin
        tests_failed++;
        $display("FAIL rand%0d_rx_count: got %0d expected %0d", t, rx_log.size() - rx0, exp_rx);
      end else begin
        for (int k = 0; k < exp_rx; k++) begin
          tests_run++;
          if (rx_log[rx0 + k] !== bytes[k]) begin
            tests_failed++;
            $display("FAIL rand%0d_rx_byte%0d: got %h expected %h", t, k, rx_log[rx0 + k],
                     bytes[k]);
          end
        end
      end
      tests_run++;
      if (tx_cnt - tx0 != ((exp_ack && rw) ? n - 1 : 0)) begin
        tests_failed++;
        $display("FAIL rand%0d_sended_count: got %0d expected %0d", t, tx_cnt - tx0,
                 (exp_ack && rw) ? n - 1 : 0);
      end
      wait_clks(10);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mismatch();
    test_read_rs();
    test_glitch();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
